mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipelined CPU.
- Sequences each access as a request/acknowledge transaction against a variable-latency memory.
- Drives a pipeline stall while any requester is waiting.
- Sits between the CPU stages and the memory model.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.

Ports:
- clk_i  in  1  clock, all logic on posedge.
- rst_i  in  1  reset, synchronous, active-low.
- if_req_i  in  1  instruction fetch request, level.
- if_addr_i  in  ADDR_W  fetch address.
- if_data_o  out  DATA_W  fetched instruction, valid with if_ack_o.
- if_ack_o  out  1  one-cycle fetch completion pulse.
- d_req_i  in  1  data access request, level.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  store data.
- d_rdata_o  out  DATA_W  load data, valid with d_ack_o.
- d_ack_o  out  1  one-cycle data completion pulse.
- mem_req_o  out  1  memory request, held until mem_ack_i.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i.
- mem_ack_i  in  1  memory completion, one-cycle pulse.
- stall_o  out  1  pipeline stall.

Behaviour:
- Reset (rst_i==0 at posedge): state IDLE; all outputs 0 (mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, both acks, both data outputs).
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - d_req_i=1: latch d_we_i/d_addr_i/d_wdata_i into mem_* regs, mem_req_o<=1, go BUSY_D. Data has priority; MEM stage is older.
  - else if_req_i=1: latch if_addr_i, mem_we_o<=0, mem_req_o<=1, go BUSY_I.
  - else stay.
- BUSY_x: hold mem_* stable. On mem_ack_i, mem_req_o<=0, latch mem_rdata_i into the granted requester's data output, pulse its ack next cycle, go RESP.
- RESP: one cycle, ack pulse visible; go IDLE. A new grant is decided in IDLE, so back-to-back accesses are spaced by at least one IDLE cycle.
- Minimum transaction latency: request at cycle N, mem_req_o at N+1, mem_ack_i at N+1 gives ack_o at N+2.
- Store: d_rdata_o unchanged on store ack.
- stall_o (combinational) = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o).
- Withdrawn request (flush): if_req_i dropped during BUSY_I means the memory transaction still completes and if_ack_o is suppressed. d_req_i is never withdrawn; dropping it is a protocol error.
- Simultaneous IF and D requests: D is served first, IF waits; IF is never starved because D requests are separated by pipeline advancement.
- mem_ack_i outside BUSY_x: ignored.
- Reset mid-transaction: abort, IDLE, mem_req_o=0; the memory is reset by the same rst_i.
- Address/data pass through unmodified; no width conversion.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: adds outputs perf_stall_cnt_o[31:0] (cycles with stall_o=1), perf_d_cnt_o[31:0] (data acks) and perf_i_cnt_o[31:0] (fetch acks). All reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package mem_arb_pkg: FSM state enum (IDLE=0, BUSY_I=1, BUSY_D=2, RESP=3), default ADDR_W/DATA_W constants.
- Optional sub-module mem_arb_perf holds the counters, instantiated only under MEM_ARB_PERF_EN.

Test Plan:
- Reset mid-BUSY_D (store, addr 0x10), rst_i=0 one cycle -> next cycle mem_req_o=0, state IDLE, no d_ack_o; memory[0x10] unchanged if mem_ack_i never arrived.
- Single fetch: if_req_i=1, addr 0x04, mem returns 0x00A00093 after 3 cycles -> if_ack_o pulses exactly once with if_data_o=0x00A00093; stall_o=1 until the ack cycle.
- Simultaneous load (addr 0x08, memory 10) and fetch (addr 0x0C) -> D served first, d_rdata_o=10; IF served after one IDLE cycle.
- Store addr 0x14 data 29 -> mem_we_o=1, mem_wdata_o=29, d_ack_o pulse, d_rdata_o keeps its prior value.
- Flush: if_req_i dropped while in BUSY_I -> mem_ack_i consumed, no if_ack_o, back to IDLE.
- With MEM_ARB_PERF_EN: 2 loads + 3 fetches, each with 2-cycle memory latency -> perf_d_cnt_o=2, perf_i_cnt_o=3, perf_stall_cnt_o equals the number of cycles stall_o was 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM unified-memory arbiter.
// The optional counter block is enabled with the MEM_ARB_PERF_EN macro.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam int PERF_W     = 32;
    localparam int PERF_NUM   = 3;
    localparam int PERF_STALL = 0;
    localparam int PERF_D     = 1;
    localparam int PERF_I     = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arb_perf.sv
// Event counters for the memory arbiter: stall cycles, data acks, fetch acks.
// Only instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf
    import mem_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              d_ack_i,
    input  logic              i_ack_i,
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] d_cnt_o,
    output logic [PERF_W-1:0] i_cnt_o
);

    logic [PERF_NUM-1:0]        evt;
    logic [PERF_NUM*PERF_W-1:0] cnt_flat;

    assign evt[PERF_STALL] = stall_i;
    assign evt[PERF_D]     = d_ack_i;
    assign evt[PERF_I]     = i_ack_i;

    // Counters wrap naturally at 2^PERF_W.
    for (genvar gi = 0; gi < PERF_NUM; gi++) begin : g_cnt
        logic [PERF_W-1:0] cnt_q;
        logic [PERF_W-1:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (evt[gi]) begin
                cnt_d = cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_flat[gi*PERF_W +: PERF_W] = cnt_q;
    end

    assign stall_cnt_o = cnt_flat[PERF_STALL*PERF_W +: PERF_W];
    assign d_cnt_o     = cnt_flat[PERF_D*PERF_W +: PERF_W];
    assign i_cnt_o     = cnt_flat[PERF_I*PERF_W +: PERF_W];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Define MEM_ARB_PERF_EN to add the perf_*_cnt_o counter outputs.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_d_cnt_o,
    output logic [31:0]       perf_i_cnt_o
`endif
);

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic              if_ack_q, if_ack_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_ack_q, d_ack_d;
    logic              if_flush_q, if_flush_d;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            if_ack_q    <= 1'b0;
            d_rdata_q   <= '0;
            d_ack_q     <= 1'b0;
            if_flush_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            if_ack_q    <= if_ack_d;
            d_rdata_q   <= d_rdata_d;
            d_ack_q     <= d_ack_d;
            if_flush_q  <= if_flush_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        if_ack_d    = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_ack_d     = 1'b0;
        if_flush_d  = if_flush_q;

        case (state_q)
            IDLE: begin
                if_flush_d = 1'b0;
                // The MEM stage holds the older instruction, so it wins ties.
                if (d_req_i) begin
                    mem_we_d    = d_we_i;
                    mem_addr_d  = d_addr_i;
                    mem_wdata_d = d_wdata_i;
                    mem_req_d   = 1'b1;
                    state_d     = BUSY_D;
                end else if (if_req_i) begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr_i;
                    mem_req_d  = 1'b1;
                    state_d    = BUSY_I;
                end
            end
            BUSY_I: begin
                // A fetch dropped at any point of the transaction is a flush:
                // the memory access still finishes but the result is discarded.
                if (!if_req_i) begin
                    if_flush_d = 1'b1;
                end
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (if_req_i && !if_flush_q) begin
                        if_data_d = mem_rdata_i;
                        if_ack_d  = 1'b1;
                    end
                end
            end
            BUSY_D: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    state_d   = RESP;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata_i;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign if_data_o   = if_data_q;
    assign if_ack_o    = if_ack_q;
    assign d_rdata_o   = d_rdata_q;
    assign d_ack_o     = d_ack_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign stall_o     = (if_req_i & ~if_ack_q) | (d_req_i & ~d_ack_q);

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf u_perf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (stall_o),
        .d_ack_i     (d_ack_q),
        .i_ack_i     (if_ack_q),
        .stall_cnt_o (perf_stall_cnt_o),
        .d_cnt_o     (perf_d_cnt_o),
        .i_cnt_o     (perf_i_cnt_o)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a variable-latency memory model.
// Counter checks run only when MEM_ARB_PERF_EN is defined.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_ack_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        stall_o;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_stall_cnt_o;
    logic [31:0] perf_d_cnt_o;
    logic [31:0] perf_i_cnt_o;
`endif

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_data_o   (if_data_o),
        .if_ack_o    (if_ack_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_rdata_o   (d_rdata_o),
        .d_ack_o     (d_ack_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .stall_o     (stall_o)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_d_cnt_o     (perf_d_cnt_o),
        .perf_i_cnt_o     (perf_i_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Memory model: acks mem_lat cycles after mem_req_o is first seen.
    logic [31:0] tmem [0:63];
    int          mem_lat  = 0;
    bit          mem_hold = 1'b0;
    int          mem_acks = 0;
    int          wcnt     = 0;

    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!rst_i) begin
                mem_ack_i = 1'b0;
                wcnt      = 0;
            end else if (mem_ack_i) begin
                mem_ack_i = 1'b0;
            end else if (mem_req_o && !mem_hold) begin
                if (wcnt >= mem_lat) begin
                    mem_ack_i = 1'b1;
                    if (mem_we_o) tmem[mem_addr_o[7:2]] = mem_wdata_o;
                    else          mem_rdata_i = tmem[mem_addr_o[7:2]];
                    wcnt = 0;
                    mem_acks++;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Cycle monitor, sampled late in each cycle after inputs have settled.
    int stall_seen = 0;
    int if_ack_seen = 0;
    int d_ack_seen = 0;

    initial begin
        forever begin
            @(negedge clk_i);
            #4;
            if (rst_i) begin
                if (stall_o)  stall_seen++;
                if (if_ack_o) if_ack_seen++;
                if (d_ack_o)  d_ack_seen++;
            end
        end
    end

    task automatic clear_mon();
        stall_seen  = 0;
        if_ack_seen = 0;
        d_ack_seen  = 0;
    endtask

    task automatic wait_ack(input bit is_d, input int max_cyc, output int n);
        logic a;
        n = 0;
        a = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_i);
            n++;
            a = is_d ? d_ack_o : if_ack_o;
            if (a) break;
        end
        if (!a) check_val(is_d ? "d_ack_timeout" : "if_ack_timeout", {31'd0, a}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n;
    int acks_before;

    initial begin
        rst_i     = 1'b0;
        if_req_i  = 1'b0;
        if_addr_i = '0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_addr_i  = '0;
        d_wdata_i = '0;
        for (int i = 0; i < 64; i++) tmem[i] = 32'hDEAD0000 | (i * 4);
        tmem[1] = 32'h00A00093;
        tmem[2] = 32'd10;
        tmem[3] = 32'h12345678;

        // Reset state
        repeat (3) @(negedge clk_i);
        check_val("rst_mem_req",   {31'd0, mem_req_o}, 32'd0);
        check_val("rst_mem_we",    {31'd0, mem_we_o}, 32'd0);
        check_val("rst_mem_addr",  mem_addr_o, 32'd0);
        check_val("rst_mem_wdata", mem_wdata_o, 32'd0);
        check_val("rst_if_ack",    {31'd0, if_ack_o}, 32'd0);
        check_val("rst_d_ack",     {31'd0, d_ack_o}, 32'd0);
        check_val("rst_if_data",   if_data_o, 32'd0);
        check_val("rst_d_rdata",   d_rdata_o, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Reset while a store is outstanding
        clear_mon();
        mem_hold  = 1'b1;
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h10;
        d_wdata_i = 32'h55;
        @(negedge clk_i);
        check_val("abort_mem_req",  {31'd0, mem_req_o}, 32'd1);
        check_val("abort_mem_addr", mem_addr_o, 32'h10);
        check_val("abort_stall",    {31'd0, stall_o}, 32'd1);
        rst_i   = 1'b0;
        d_req_i = 1'b0;
        d_we_i  = 1'b0;
        @(negedge clk_i);
        check_val("abort_req_clr", {31'd0, mem_req_o}, 32'd0);
        check_val("abort_d_ack",   {31'd0, d_ack_o}, 32'd0);
        rst_i    = 1'b1;
        mem_hold = 1'b0;
        repeat (3) @(negedge clk_i);
        check_val("abort_idle_req", {31'd0, mem_req_o}, 32'd0);
        check_val("abort_no_ack",   d_ack_seen, 32'd0);
        check_val("abort_mem_0x10", tmem[4], 32'hDEAD0010);

        // Single fetch, 3-cycle memory latency
        clear_mon();
        mem_lat   = 3;
        if_req_i  = 1'b1;
        if_addr_i = 32'h04;
        wait_ack(1'b0, 20, n);
        check_val("fetch_latency", n, 32'd5);
        check_val("fetch_data",    if_data_o, 32'h00A00093);
        check_val("fetch_stall_ack", {31'd0, stall_o}, 32'd0);
        if_req_i = 1'b0;
        @(negedge clk_i);
        check_val("fetch_ack_once", if_ack_seen, 32'd1);
        check_val("fetch_ack_low",  {31'd0, if_ack_o}, 32'd0);
        check_val("fetch_stall_cyc", stall_seen, 32'd5);

        // Simultaneous load and fetch: data goes first
        clear_mon();
        mem_lat   = 1;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_addr_i  = 32'h08;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0C;
        wait_ack(1'b1, 20, n);
        check_val("both_d_latency", n, 32'd3);
        check_val("both_d_rdata",   d_rdata_o, 32'd10);
        check_val("both_if_wait",   {31'd0, if_ack_o}, 32'd0);
        check_val("both_if_stall",  {31'd0, stall_o}, 32'd1);
        d_req_i = 1'b0;
        @(negedge clk_i);
        check_val("both_idle_gap", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk_i);
        check_val("both_if_grant", {31'd0, mem_req_o}, 32'd1);
        check_val("both_if_addr",  mem_addr_o, 32'h0C);
        check_val("both_if_we",    {31'd0, mem_we_o}, 32'd0);
        wait_ack(1'b0, 20, n);
        check_val("both_if_latency", n, 32'd2);
        check_val("both_if_data",    if_data_o, 32'h12345678);
        if_req_i = 1'b0;
        @(negedge clk_i);

        // Store: d_rdata_o must keep the previous load value
        clear_mon();
        mem_lat   = 0;
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h14;
        d_wdata_i = 32'd29;
        @(negedge clk_i);
        check_val("store_we",    {31'd0, mem_we_o}, 32'd1);
        check_val("store_wdata", mem_wdata_o, 32'd29);
        check_val("store_addr",  mem_addr_o, 32'h14);
        wait_ack(1'b1, 20, n);
        check_val("store_latency", n, 32'd1);
        check_val("store_rdata_kept", d_rdata_o, 32'd10);
        d_req_i = 1'b0;
        d_we_i  = 1'b0;
        @(negedge clk_i);
        check_val("store_mem_0x14", tmem[5], 32'd29);
        check_val("store_ack_once", d_ack_seen, 32'd1);

        // Flush: fetch withdrawn while the memory is busy
        clear_mon();
        mem_lat     = 2;
        acks_before = mem_acks;
        if_req_i    = 1'b1;
        if_addr_i   = 32'h04;
        @(negedge clk_i);
        check_val("flush_mem_req", {31'd0, mem_req_o}, 32'd1);
        if_req_i = 1'b0;
        repeat (6) @(negedge clk_i);
        check_val("flush_no_ack",    if_ack_seen, 32'd0);
        check_val("flush_mem_acked", mem_acks - acks_before, 32'd1);
        check_val("flush_req_low",   {31'd0, mem_req_o}, 32'd0);
        check_val("flush_if_data",   if_data_o, 32'h12345678);
        mem_lat   = 0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0C;
        wait_ack(1'b0, 20, n);
        check_val("after_flush_latency", n, 32'd2);
        if_req_i = 1'b0;
        @(negedge clk_i);

`ifdef MEM_ARB_PERF_EN
        begin
            bit          pv_d    [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
            logic [31:0] pv_addr [5] = '{32'h08, 32'h04, 32'h14, 32'h0C, 32'h00};
            logic [31:0] pv_exp  [5] = '{32'd10, 32'h00A00093, 32'd29, 32'h12345678, 32'hDEAD0000};
            rst_i = 1'b0;
            clear_mon();
            @(negedge clk_i);
            rst_i   = 1'b1;
            mem_lat = 2;
            for (int k = 0; k < 5; k++) begin
                if (pv_d[k]) begin
                    d_req_i  = 1'b1;
                    d_we_i   = 1'b0;
                    d_addr_i = pv_addr[k];
                end else begin
                    if_req_i  = 1'b1;
                    if_addr_i = pv_addr[k];
                end
                wait_ack(pv_d[k], 20, n);
                check_val("perf_xact_data", pv_d[k] ? d_rdata_o : if_data_o, pv_exp[k]);
                d_req_i  = 1'b0;
                if_req_i = 1'b0;
                @(negedge clk_i);
            end
            check_val("perf_d_cnt",     perf_d_cnt_o, 32'd2);
            check_val("perf_i_cnt",     perf_i_cnt_o, 32'd3);
            check_val("perf_stall_mon", perf_stall_cnt_o, stall_seen);
            check_val("perf_stall_cnt", perf_stall_cnt_o, 32'd20);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
